// File: rtl/debug_register_reader.sv
// Snapshot-and-stream readout of the wide debug register as framed 32-bit words.
// Latency: header beat valid the cycle after the request handshake; WORD_NUM+2 beats per dump.
// Backpressure: outData/outLast hold while outValid && !outReady; requests only accepted in IDLE.
//
// Ports:
//   clk, rst          - rising-edge clock, asynchronous active-low reset
//   debugRegister     - live debug register value (DEBUG_WIDTH bits)
//   reqValid/reqReady - dump request handshake, reqTag echoed in the header
//   outValid/outReady - beat handshake; outData payload, outLast marks the checksum beat
//   busy              - a dump is in progress
//   dumpCount         - completed dumps, wraps modulo 2^16
module debug_register_reader #(
  parameter int DEBUG_WIDTH = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DEBUG_WIDTH-1:0] debugRegister,
  input  logic                   reqValid,
  input  logic [7:0]             reqTag,
  output logic                   reqReady,
  output logic                   outValid,
  input  logic                   outReady,
  output logic [31:0]            outData,
  output logic                   outLast,
  output logic                   busy,
  output logic [15:0]            dumpCount
);

  localparam int          WORD_NUM = (DEBUG_WIDTH + 31) / 32;
  localparam int          PAD_W    = WORD_NUM * 32;
  localparam logic [15:0] WORD_N16 = 16'(WORD_NUM);
  localparam logic [15:0] LAST_IDX = 16'(WORD_NUM - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_HEADER   = 2'd1,
    S_DATA     = 2'd2,
    S_CHECKSUM = 2'd3
  } state_t;

  state_t            r_state;
  logic [PAD_W-1:0]  r_snap;
  logic [7:0]        r_tag;
  logic [15:0]       r_idx;
  logic [31:0]       r_acc;
  logic [31:0]       r_out_data;
  logic [15:0]       r_dump_count;

  logic [PAD_W-1:0]  w_dbg_pad;
  logic [PAD_W-1:0]  w_snap_next;
  logic              w_out_hs;

  // Zero-extend the live value so bits above DEBUG_WIDTH in the final word read as zero.
  always_comb begin
    w_dbg_pad                  = '0;
    w_dbg_pad[DEBUG_WIDTH-1:0] = debugRegister;
  end

  // The snapshot is consumed as a shift register: the next word to send is always in bits [31:0].
  assign w_snap_next = r_snap >> 32;
  assign w_out_hs    = (r_state != S_IDLE) && outReady;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_snap       <= '0;
      r_tag        <= '0;
      r_idx        <= '0;
      r_acc        <= '0;
      r_out_data   <= '0;
      r_dump_count <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (reqValid) begin
            r_snap     <= w_dbg_pad;
            r_tag      <= reqTag;
            r_idx      <= '0;
            r_acc      <= '0;
            r_out_data <= {8'hD5, reqTag, WORD_N16};
            r_state    <= S_HEADER;
          end
        end
        S_HEADER: begin
          if (w_out_hs) begin
            r_acc      <= r_acc + r_out_data;
            r_out_data <= r_snap[31:0];
            r_snap     <= w_snap_next;
            r_state    <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_out_hs) begin
            r_acc <= r_acc + r_out_data;
            r_idx <= r_idx + 16'd1;
            if (r_idx == LAST_IDX) begin
              // Checksum beat includes the word being accepted right now.
              r_out_data <= r_acc + r_out_data;
              r_state    <= S_CHECKSUM;
            end else begin
              r_out_data <= r_snap[31:0];
              r_snap     <= w_snap_next;
            end
          end
        end
        S_CHECKSUM: begin
          if (w_out_hs) begin
            r_dump_count <= r_dump_count + 16'd1;
            r_out_data   <= '0;
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Handshake-side outputs decode the registered state only.
  assign reqReady  = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign outValid  = (r_state != S_IDLE);
  assign outLast   = (r_state == S_CHECKSUM);
  assign outData   = r_out_data;
  assign dumpCount = r_dump_count;

endmodule
